// File: rtl/ex_bus_responder_pkg.sv
// ex_bus_responder_pkg: shared widths, ex_bus field offsets, posted-write entry type, bank-group decode helper
package ex_bus_responder_pkg;
    localparam int A_W        = 10;
    localparam int D_W        = 32;
    localparam int NUM_BG     = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int WA_W       = A_W - 2;
    localparam int BUS_W      = 2 + A_W + D_W;
    localparam int WEN_BIT    = BUS_W - 1;
    localparam int REN_BIT    = BUS_W - 2;
    localparam int ADDR_LSB   = D_W;
    localparam int DATA_LSB   = 0;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int LVL_W      = PTR_W + 1;

    typedef logic [1:0] bg_t;

    typedef struct packed {
        bg_t             bg;
        logic [WA_W-1:0] addr;
        logic [D_W-1:0]  data;
    } wr_entry_t;

    function automatic logic [NUM_BG-1:0] bg_onehot(input bg_t bg);
        return NUM_BG'(1) << bg;
    endfunction
endpackage

// File: rtl/ex_bus_responder_wr_fifo.sv
// ex_bus_responder_wr_fifo: ordered posted-write FIFO with combinational {bg,addr} match
//   push/pop/din -> enqueue/dequeue, dout = head entry
//   full/empty/level -> occupancy (pointers carry a wrap bit)
//   match_bg/match_addr -> match: any valid entry targets that location
module ex_bus_responder_wr_fifo
    import ex_bus_responder_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  wr_entry_t        din,
    input  bg_t              match_bg,
    input  logic [WA_W-1:0]  match_addr,
    output wr_entry_t        dout,
    output logic             full,
    output logic             empty,
    output logic             match,
    output logic [LVL_W-1:0] level
);
    wr_entry_t        mem [FIFO_DEPTH];
    logic [LVL_W-1:0] wp, rp;

    assign level = wp - rp;
    assign full  = level == LVL_W'(FIFO_DEPTH);
    assign empty = level == '0;
    assign dout  = mem[rp[PTR_W-1:0]];

    // Slot i is live when its distance from the read pointer is below the level.
    always_comb begin
        match = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++)
            match = match | (({1'b0, PTR_W'(i) - rp[PTR_W-1:0]} < level) &&
                             mem[i].bg == match_bg && mem[i].addr == match_addr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            wp <= wp + LVL_W'(push);
            rp <= rp + LVL_W'(pop);
        end
    end

    always_ff @(posedge clk)
        if (push) mem[wp[PTR_W-1:0]] <= din;
endmodule

// File: rtl/ex_bus_responder.sv
// ex_bus_responder: SPM-side terminator of ex_bus, routing host writes/reads to four bank groups
//   ex_bus {wen,ren,addr,data} in; bg_en/bg_sel give per-BG external ownership
//   bg_wen/bg_waddr/bg_wdata: registered bank writes (direct or drained from FIFO)
//   bg_ren/bg_raddr out, bg_rdata in: bank reads; ex_rdata/ex_rvalid/ex_rerr: response at T+2
//   fifo_level: pending posted writes; err_drop/err_conf: sticky error flags
module ex_bus_responder
    import ex_bus_responder_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BUS_W-1:0]      ex_bus,
    input  logic [NUM_BG-1:0]     bg_en,
    input  logic [NUM_BG-1:0]     bg_sel,
    output logic [NUM_BG-1:0]     bg_wen,
    output logic [WA_W-1:0]       bg_waddr,
    output logic [D_W-1:0]        bg_wdata,
    output logic [NUM_BG-1:0]     bg_ren,
    output logic [WA_W-1:0]       bg_raddr,
    input  logic [NUM_BG*D_W-1:0] bg_rdata,
    output logic [D_W-1:0]        ex_rdata,
    output logic                  ex_rvalid,
    output logic                  ex_rerr,
    output logic [LVL_W-1:0]      fifo_level,
    output logic                  err_drop,
    output logic                  err_conf
);
    logic        wen, ren, rd, rd_ok, hit;
    logic        full, empty, push, pop, direct, drop, issue;
    logic        s1_valid, s1_err;
    bg_t         s1_bg, r_bg;
    logic [NUM_BG-1:0] avail;
    wr_entry_t   req, head, wr;

    assign wen   = ex_bus[WEN_BIT];
    assign ren   = ex_bus[REN_BIT];
    assign req   = '{bg: ex_bus[ADDR_LSB+A_W-1 -: 2], addr: ex_bus[ADDR_LSB +: WA_W],
                     data: ex_bus[DATA_LSB +: D_W]};
    assign avail = bg_en & ~bg_sel;

    // A direct write needs an empty FIFO, so it can never overtake a drain.
    assign pop    = !empty && avail[head.bg];
    assign direct = wen && empty && avail[req.bg];
    assign push   = wen && !direct && (!full || pop);
    assign drop   = wen && !direct && full && !pop;
    assign issue  = pop || direct;
    assign wr     = pop ? head : req;

    // Reads to a location with a pending posted write are rejected rather than returning stale data.
    assign rd    = ren && !wen;
    assign rd_ok = rd && avail[req.bg] && !hit;

    ex_bus_responder_wr_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .din       (req),
        .match_bg  (req.bg),
        .match_addr(req.addr),
        .dout      (head),
        .full      (full),
        .empty     (empty),
        .match     (hit),
        .level     (fifo_level)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bg_wen   <= '0;
            bg_waddr <= '0;
            bg_wdata <= '0;
        end else begin
            bg_wen <= issue ? bg_onehot(wr.bg) : '0;
            if (issue) begin
                bg_waddr <= wr.addr;
                bg_wdata <= wr.data;
            end
        end
    end

    // Stage 1 issues the bank read; stage 2 aligns with bank data one cycle later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bg_ren    <= '0;
            bg_raddr  <= '0;
            s1_valid  <= 1'b0;
            s1_err    <= 1'b0;
            s1_bg     <= '0;
            ex_rvalid <= 1'b0;
            ex_rerr   <= 1'b0;
            r_bg      <= '0;
        end else begin
            bg_ren   <= rd_ok ? bg_onehot(req.bg) : '0;
            s1_valid <= rd;
            s1_err   <= rd && !rd_ok;
            if (rd) begin
                bg_raddr <= req.addr;
                s1_bg    <= req.bg;
            end
            ex_rvalid <= s1_valid;
            ex_rerr   <= s1_valid && s1_err;
            r_bg      <= s1_bg;
        end
    end

    assign ex_rdata = (ex_rvalid && !ex_rerr) ? bg_rdata[32'(r_bg)*D_W +: D_W] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_drop <= 1'b0;
            err_conf <= 1'b0;
        end else begin
            err_drop <= err_drop | drop;
            err_conf <= err_conf | (wen && ren);
        end
    end
endmodule

// File: tb/tb_ex_bus_responder.sv
// tb_ex_bus_responder: directed checks of write posting, drain order, reads, hazards and reset
module tb_ex_bus_responder;
    logic         clk = 1'b0;
    logic         rst;
    logic [43:0]  ex_bus;
    logic [3:0]   bg_en, bg_sel, bg_wen, bg_ren;
    logic [7:0]   bg_waddr, bg_raddr;
    logic [31:0]  bg_wdata, ex_rdata;
    logic [127:0] bg_rdata = '0;
    logic         ex_rvalid, ex_rerr, err_drop, err_conf;
    logic [2:0]   fifo_level;
    int           n_chk = 0;
    int           n_fail = 0;
    logic [31:0]  exp_rd [5] = '{32'hDEAD, 32'h4, 32'h5, 32'h6, 32'h7};

    ex_bus_responder dut (
        .clk(clk), .rst(rst), .ex_bus(ex_bus), .bg_en(bg_en), .bg_sel(bg_sel),
        .bg_wen(bg_wen), .bg_waddr(bg_waddr), .bg_wdata(bg_wdata),
        .bg_ren(bg_ren), .bg_raddr(bg_raddr), .bg_rdata(bg_rdata),
        .ex_rdata(ex_rdata), .ex_rvalid(ex_rvalid), .ex_rerr(ex_rerr),
        .fifo_level(fifo_level), .err_drop(err_drop), .err_conf(err_conf)
    );

    always #5 clk = ~clk;

    // Bank SRAM model: 1-cycle read latency, BG0 word 3 holds 0xDEAD, else (bg<<12)|addr.
    always @(posedge clk)
        for (int b = 0; b < 4; b++)
            if (bg_ren[b])
                bg_rdata[b*32 +: 32] <= (b == 0 && bg_raddr == 8'd3) ? 32'hDEAD
                                        : (32'(b) << 12) | 32'(bg_raddr);

    function automatic logic [43:0] bus(input logic w, input logic r, input logic [9:0] a,
                                        input logic [31:0] d);
        return {w, r, a, d};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0;
        ex_bus = '0;
        bg_en = 4'hF;
        bg_sel = 4'h0;
        step();
        step();
        chk("rst_wen", bg_wen, 0);
        chk("rst_ren", bg_ren, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_rvalid", ex_rvalid, 0);
        chk("rst_drop", err_drop, 0);
        chk("rst_conf", err_conf, 0);
        rst = 1'b1;
        // 1: direct write
        ex_bus = bus(1, 0, 10'h005, 32'hA5);
        step();
        ex_bus = '0;
        chk("t1_wen", bg_wen, 4'b0001);
        chk("t1_waddr", bg_waddr, 5);
        chk("t1_wdata", bg_wdata, 32'hA5);
        chk("t1_level", fifo_level, 0);
        step();
        chk("t1_wen_off", bg_wen, 0);
        // 2: posted writes to BG1, then drain in order
        bg_sel = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            ex_bus = bus(1, 0, 10'h100 + 10'(i), 32'h11 * 32'(i + 1));
            step();
        end
        ex_bus = '0;
        chk("t2_level3", fifo_level, 3);
        chk("t2_no_wen", bg_wen, 0);
        bg_sel = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t2_drain_wen", bg_wen, 4'b0010);
            chk("t2_drain_addr", bg_waddr, i);
            chk("t2_drain_data", bg_wdata, 32'h11 * (i + 1));
            chk("t2_drain_level", fifo_level, 2 - i);
        end
        step();
        chk("t2_idle_wen", bg_wen, 0);
        // 3: FIFO overflow on blocked BG2
        bg_sel = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            ex_bus = bus(1, 0, 10'h200 + 10'(i), 32'h50 + 32'(i));
            step();
            if (i == 3) chk("t3_drop_before", err_drop, 0);
        end
        ex_bus = '0;
        chk("t3_level_full", fifo_level, 4);
        chk("t3_drop", err_drop, 1);
        chk("t3_no_wen", bg_wen, 0);
        bg_sel = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t3_drain_wen", bg_wen, 4'b0100);
            chk("t3_drain_addr", bg_waddr, i);
            chk("t3_drain_data", bg_wdata, 32'h50 + i);
        end
        step();
        chk("t3_fifth_absent", bg_wen, 0);
        chk("t3_level0", fifo_level, 0);
        // 4: single read then back-to-back reads
        for (int i = 0; i < 7; i++) begin
            ex_bus = (i < 5) ? bus(0, 1, (i == 0) ? 10'h003 : 10'h003 + 10'(i), 0) : '0;
            step();
            if (i == 0) begin
                chk("t4_ren", bg_ren, 4'b0001);
                chk("t4_raddr", bg_raddr, 3);
                chk("t4_no_rvalid_t1", ex_rvalid, 0);
            end
            if (i >= 1 && i <= 5) begin
                chk("t4_rvalid", ex_rvalid, 1);
                chk("t4_rerr", ex_rerr, 0);
                chk("t4_rdata", ex_rdata, exp_rd[i-1]);
            end
            if (i == 6) chk("t4_rvalid_end", ex_rvalid, 0);
        end
        // 5a: read to disabled BG3
        bg_en = 4'b0111;
        ex_bus = bus(0, 1, 10'h305, 0);
        step();
        ex_bus = '0;
        chk("t5_dis_ren", bg_ren, 0);
        step();
        chk("t5_dis_rvalid", ex_rvalid, 1);
        chk("t5_dis_rerr", ex_rerr, 1);
        chk("t5_dis_rdata", ex_rdata, 0);
        bg_en = 4'hF;
        // 6a: wen and ren together
        ex_bus = bus(1, 1, 10'h006, 32'h66);
        step();
        ex_bus = '0;
        chk("t6_conf_wen", bg_wen, 4'b0001);
        chk("t6_conf_waddr", bg_waddr, 6);
        chk("t6_conf_wdata", bg_wdata, 32'h66);
        chk("t6_conf_ren", bg_ren, 0);
        chk("t6_conf_flag", err_conf, 1);
        step();
        chk("t6_conf_no_rvalid", ex_rvalid, 0);
        // 5b: read hitting a pending FIFO entry on an available BG
        bg_sel = 4'b0100;
        ex_bus = bus(1, 0, 10'h210, 32'h77);
        step();
        ex_bus = bus(1, 0, 10'h00A, 32'h88);
        step();
        ex_bus = bus(0, 1, 10'h00A, 0);
        step();
        ex_bus = '0;
        chk("t5_hit_level", fifo_level, 2);
        chk("t5_hit_ren", bg_ren, 0);
        chk("t5_hit_no_wen", bg_wen, 0);
        step();
        chk("t5_hit_rvalid", ex_rvalid, 1);
        chk("t5_hit_rerr", ex_rerr, 1);
        chk("t5_hit_rdata", ex_rdata, 0);
        // 6b: async reset mid-drain
        bg_sel = 4'b0000;
        step();
        chk("t6_drain_wen", bg_wen, 4'b0100);
        chk("t6_drain_addr", bg_waddr, 8'h10);
        chk("t6_drain_level", fifo_level, 1);
        rst = 1'b0;
        #1;
        chk("t6_rst_wen", bg_wen, 0);
        chk("t6_rst_waddr", bg_waddr, 0);
        chk("t6_rst_level", fifo_level, 0);
        chk("t6_rst_drop", err_drop, 0);
        chk("t6_rst_conf", err_conf, 0);
        #1;
        rst = 1'b1;
        step();
        chk("t6_after_wen", bg_wen, 0);
        chk("t6_after_level", fifo_level, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
